// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory port arbiter: owner tags, arbiter FSM states
// and the byte-enable and wait-counter widths.
package riscv_mem_pkg;

  localparam int unsigned BE_W   = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_CPU_PRI   = 1'b0,
    ARB_DMA_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive refused DMA cycles. The count saturates at MAX_WAIT.
// at_thresh_o is high when the next refusal would bring the count to MAX_WAIT.
module arb_starve_counter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_thresh_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != WAIT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_thresh_o = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data BRAM arbiter. CPU has fixed priority, and a DMA grant is forced
// after MAX_WAIT refusals. Each granted read is tagged so the data returned one cycle later goes to its issuer.
module dmem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BE_W-1:0]   cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [BE_W-1:0]   dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  owner_e     rd_tag_q, rd_tag_d;
  logic       cpu_grant, dma_grant;
  logic       at_thresh;
  logic       dma_refused;

  // Grants are made in the request cycle. Holding reset blocks all grants.
  always_comb begin
    state_d   = state_q;
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ARB_CPU_PRI: begin
          if (cpu_req) begin
            cpu_grant = 1'b1;
          end else if (dma_req) begin
            dma_grant = 1'b1;
          end
          if (dma_req && cpu_req && at_thresh) begin
            state_d = ARB_DMA_FORCE;
          end
        end
        ARB_DMA_FORCE: begin
          dma_grant = dma_req;
          state_d   = ARB_CPU_PRI;
        end
        default: state_d = ARB_CPU_PRI;
      endcase
    end
  end

  assign dma_refused = dma_req && !dma_grant;

  arb_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (dma_refused),
    .clr_i      (!dma_refused),
    .at_thresh_o(at_thresh)
  );

  // Record the owner of a granted read so that the data returned next cycle goes to that requester.
  always_comb begin
    rd_tag_d = OWN_NONE;
    if (cpu_grant && (cpu_we == '0)) begin
      rd_tag_d = OWN_CPU;
    end else if (dma_grant && (dma_we == '0)) begin
      rd_tag_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_CPU_PRI;
      rd_tag_q <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  assign mem_en    = cpu_grant || dma_grant;
  assign mem_addr  = dma_grant ? dma_addr : cpu_addr;
  assign mem_wdata = dma_grant ? dma_wdata : cpu_wdata;
  assign mem_we    = cpu_grant ? cpu_we : (dma_grant ? dma_we : '0);

  assign cpu_stall  = cpu_req && !cpu_grant;
  assign dma_gnt    = dma_grant;
  assign cpu_rvalid = (rd_tag_q == OWN_CPU);
  assign dma_rvalid = (rd_tag_q == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter. Each cycle checks grants and the mem_* mux directly.
// Expected read returns are queued and compared one cycle later.
module tb_dmem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, dma_req;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [BE_W-1:0]   cpu_we, dma_we;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'h5A, 2'b10, a, 8'hC3};
  endfunction

  // BRAM stand-in: returns a registered, address-derived word one cycle after a read.
  always @(posedge clk) begin
    if (mem_en && (mem_we == '0)) mem_rdata <= word_of(mem_addr);
    else                          mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic creq, input logic [ADDR_W-1:0] caddr, input logic [3:0] cwe,
                      input logic dreq, input logic [ADDR_W-1:0] daddr, input logic [3:0] dwe,
                      input logic exp_cg, input logic exp_dg, input string tag);
    exp_t prev, nxt;
    logic [3:0] exp_we;
    @(negedge clk);
    cpu_req = creq; cpu_addr = caddr; cpu_we = cwe; cpu_wdata = $urandom;
    dma_req = dreq; dma_addr = daddr; dma_we = dwe; dma_wdata = $urandom;
    #1;
    if (exp_q.size() == 0) begin
      prev.own  = OWN_NONE;
      prev.data = '0;
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: scoreboard empty", tag);
    end else begin
      prev = exp_q.pop_front();
    end
    check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'(prev.own == OWN_CPU));
    check_eq({tag, "_dma_rvalid"}, 32'(dma_rvalid), 32'(prev.own == OWN_DMA));
    if (prev.own == OWN_CPU) check_eq({tag, "_cpu_rdata"}, cpu_rdata, prev.data);
    if (prev.own == OWN_DMA) check_eq({tag, "_dma_rdata"}, dma_rdata, prev.data);
    exp_we = exp_cg ? cwe : (exp_dg ? dwe : 4'b0000);
    check_eq({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(creq && !exp_cg));
    check_eq({tag, "_dma_gnt"},   32'(dma_gnt),   32'(exp_dg));
    check_eq({tag, "_mem_en"},    32'(mem_en),    32'(exp_cg || exp_dg));
    check_eq({tag, "_mem_we"},    32'(mem_we),    32'(exp_we));
    if (exp_cg) begin
      check_eq({tag, "_mem_addr"},  32'(mem_addr), 32'(caddr));
      check_eq({tag, "_mem_wdata"}, mem_wdata,     cpu_wdata);
    end
    if (exp_dg) begin
      check_eq({tag, "_mem_addr"},  32'(mem_addr), 32'(daddr));
      check_eq({tag, "_mem_wdata"}, mem_wdata,     dma_wdata);
    end
    if (exp_cg && (cwe == 4'b0000))      nxt.own = OWN_CPU;
    else if (exp_dg && (dwe == 4'b0000)) nxt.own = OWN_DMA;
    else                                 nxt.own = OWN_NONE;
    nxt.data = exp_cg ? word_of(caddr) : word_of(daddr);
    exp_q.push_back(nxt);
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cpu_stall"},  32'(cpu_stall),  32'(cpu_req));
    check_eq({tag, "_dma_gnt"},    32'(dma_gnt),    32'd0);
    check_eq({tag, "_mem_en"},     32'(mem_en),     32'd0);
    check_eq({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check_eq({tag, "_dma_rvalid"}, 32'(dma_rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 14'h0010; cpu_we = 4'b0000; cpu_wdata = '0;
    dma_req = 1'b1; dma_addr = 14'h0020; dma_we = 4'b0000; dma_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back('{OWN_NONE, 32'h0});

    // CPU read with no DMA traffic; its data must return only to the CPU.
    step(1'b1, 14'h0010, 4'b0000, 1'b0, '0, 4'b0000, 1'b1, 1'b0, "cpu_rd");
    idle("cpu_rd_ret");

    // CPU write and DMA read in the same cycle: the CPU wins, then the DMA is served.
    step(1'b1, 14'h0030, 4'b0011, 1'b1, 14'h0444, 4'b0000, 1'b1, 1'b0, "col_wr");
    step(1'b0, '0, 4'b0000, 1'b1, 14'h0444, 4'b0000, 1'b0, 1'b1, "col_dma");
    idle("col_ret");

    // Continuous contention: the DMA is forced through every ninth cycle.
    for (int i = 0; i < 27; i++) begin
      step(1'b1, 14'(14'h0100 + i), 4'b0000, 1'b1, 14'(14'h0800 + i), 4'b0000,
           (i % 9) != 8, (i % 9) == 8, $sformatf("contend%0d", i));
    end
    idle("contend_end");

    // Reads from alternating owners on consecutive cycles.
    step(1'b1, 14'h0A01, 4'b0000, 1'b0, '0, 4'b0000, 1'b1, 1'b0, "alt_c0");
    step(1'b0, '0, 4'b0000, 1'b1, 14'h0B02, 4'b0000, 1'b0, 1'b1, "alt_d1");
    step(1'b1, 14'h0A03, 4'b0000, 1'b0, '0, 4'b0000, 1'b1, 1'b0, "alt_c2");
    idle("alt_ret");

    // The DMA drops its request after five refusals, so the wait count starts again from zero.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 14'(14'h0200 + i), 4'b0000, 1'b1, 14'h0900, 4'b0000, 1'b1, 1'b0,
           $sformatf("drop_pre%0d", i));
    end
    step(1'b1, 14'h0210, 4'b0000, 1'b0, '0, 4'b0000, 1'b1, 1'b0, "drop_gap");
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 14'(14'h0300 + i), 4'b1111, 1'b1, 14'(14'h0980 + i), 4'b0000,
           i != 8, i == 8, $sformatf("drop_post%0d", i));
    end
    idle("drop_end");

    // Reset is asserted the cycle after a granted CPU read, so that read's return is dropped.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 14'(14'h0400 + i), 4'b0000, 1'b1, 14'h0C00, 4'b0000, 1'b1, 1'b0,
           $sformatf("rst_pre%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    exp_q.push_back('{OWN_NONE, 32'h0});
    @(negedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 14'(14'h0500 + i), 4'b0000, 1'b1, 14'(14'h0D00 + i), 4'b0000,
           i != 8, i == 8, $sformatf("post_rst%0d", i));
    end
    idle("post_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates the single-ported data BRAM between two requesters. The pipeline (CPU) side is fed by the store-alignment/byte-enable logic in the EX stage. The DMA side is a loader or peripheral master. CPU has fixed priority; a starvation counter forces a DMA grant after MAX_WAIT lost cycles. The block also tags each read so that the 1-cycle-latency BRAM read data is steered back to the requester that issued it.

Parameters:
ADDR_W, 14, word-address width into the BRAM.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
MAX_WAIT, 8, consecutive cycles DMA may be refused before a forced grant (1..255).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access this cycle
cpu_addr  in  ADDR_W  CPU word address
cpu_we  in  4  CPU byte write enables; 0 means read
cpu_wdata  in  DATA_W  CPU write data, already lane-aligned
cpu_stall  out  1  CPU request refused this cycle; hold request
cpu_rvalid  out  1  cpu_rdata valid (cycle after granted CPU read)
cpu_rdata  out  DATA_W  read data to CPU
dma_req  in  1  DMA access request
dma_addr  in  ADDR_W  DMA word address
dma_we  in  4  DMA byte enables; 0 means read
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA request accepted this cycle
dma_rvalid  out  1  dma_rdata valid
dma_rdata  out  DATA_W  read data to DMA
mem_en  out  1  BRAM enable
mem_addr  out  ADDR_W  BRAM address
mem_we  out  4  BRAM byte write enables
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data (registered in BRAM, 1-cycle latency)

Behaviour:
- Grant logic is combinational in the request cycle. Registered state: the starvation counter wait_cnt (8 bit), the FSM state, and the read tag rd_tag {NONE, CPU, DMA}.
- FSM states:
  - CPU_PRI: grant CPU if cpu_req; else grant DMA if dma_req.
  - DMA_FORCE: grant DMA if dma_req, and cpu_stall = cpu_req.
- FSM transitions:
  - CPU_PRI -> DMA_FORCE when dma_req && !dma_gnt && wait_cnt == MAX_WAIT-1 (the counter is about to reach MAX_WAIT).
  - DMA_FORCE -> CPU_PRI after exactly one cycle, whether or not dma_req is still high (it is one-shot).
- wait_cnt:
  - increments each cycle dma_req && !dma_gnt, saturating at MAX_WAIT;
  - clears on any DMA grant or when dma_req is low.
- The granted requester's addr/we/wdata are muxed onto mem_*, and mem_en = 1. With no grant: mem_en = 0, mem_we = 0; mem_addr/mem_wdata are don't-care but driven from the CPU side.
- Never grant both requesters in one cycle. cpu_stall = cpu_req && !cpu_grant.
- Read tag:
  - On a granted read (we == 0), rd_tag <= owner; on a granted write or no grant, rd_tag <= NONE.
  - Next cycle: cpu_rvalid = (rd_tag == CPU), dma_rvalid = (rd_tag == DMA).
  - cpu_rdata and dma_rdata both carry mem_rdata; only rvalid qualifies them.
- Back-to-back reads from alternating owners are legal and each return is tagged correctly.
- Writes return no rvalid.
- Reset (async assert, sync-safe deassert is handled upstream): wait_cnt = 0, state = CPU_PRI, rd_tag = NONE. While rst_n is low: no grants, mem_en = 0, mem_we = 0, cpu_rvalid = dma_rvalid = 0, cpu_stall = cpu_req, dma_gnt = 0.
- Reset asserted mid-read: the pending rvalid is dropped. The requester must reissue.
- MAX_WAIT = 1: DMA is forced every other cycle under continuous contention.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - owner encoding OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2;
  - FSM encoding ARB_CPU_PRI = 1'b0, ARB_DMA_FORCE = 1'b1;
  - the byte-enable width constant.
- One natural sub-module: arb_starve_counter (saturating counter with clear, emits the at-threshold flag).

Test Plan:
- CPU read addr 0x0010, no DMA -> mem_en = 1, mem_addr = 0x0010, cpu_stall = 0; next cycle cpu_rvalid = 1 with mem_rdata, dma_rvalid = 0.
- Simultaneous single-cycle cpu_req write (we = 4'b0011) and dma_req read -> CPU granted, cpu_stall = 0, dma_gnt = 0. Next cycle with CPU idle, DMA granted; rvalid goes to DMA only.
- Continuous cpu_req and dma_req with MAX_WAIT = 8 -> dma_gnt low for 8 cycles, high on cycle 9 with cpu_stall = 1, then CPU regains the grant on cycle 10; the pattern repeats every 9 cycles.
- Alternating granted reads CPU, DMA, CPU on consecutive cycles -> rvalid sequence cpu, dma, cpu one cycle later, each paired with the correct mem_rdata word.
- dma_req drops at wait_cnt = 5 then reasserts -> counter restarts from 0; forced grant only after 8 more refused cycles.
- rst_n pulled low the cycle after a granted CPU read -> cpu_rvalid = 0 immediately, state = CPU_PRI, wait_cnt = 0; after release, a normal grant resumes on the first request.
